// File: rtl/slice_serial_alu.sv
// Slice-serial ALU: computes a WIDTH-bit result SLICE bits per cycle, LSB slice first.
// Define SLICE_SERIAL_ALU_OVF_EN to add the signed-overflow output ovf.
module slice_serial_alu #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             ALU_COUT,
    output logic             zero
`ifdef SLICE_SERIAL_ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_PSA = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt;
    logic [2:0]       op_s;
    logic             carry;
    logic [CW-1:0]    slice_cnt;
    logic             accept, last_slice, is_arith, slice_cout;
    logic [SLICE-1:0] a_sl, b_sl, b_eff, slice_res;
    logic [SLICE:0]   sum;
    int               sl_base;

    assign accept     = in_valid && in_ready;
    assign last_slice = (slice_cnt == CW'(NSL - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
    end

    // One slice of the datapath; the carry chain only matters for ADD/SUB.
    always_comb begin
        sl_base  = int'(slice_cnt) * SLICE;
        a_sl     = op_a[sl_base +: SLICE];
        b_sl     = op_b[sl_base +: SLICE];
        b_eff    = (op_s == OP_SUB) ? ~b_sl : b_sl;
        sum      = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry};
        is_arith = (op_s == OP_ADD) || (op_s == OP_SUB);
        slice_cout = is_arith && sum[SLICE];
        case (op_s)
            OP_ADD, OP_SUB: slice_res = sum[SLICE-1:0];
            OP_AND:         slice_res = a_sl & b_sl;
            OP_OR:          slice_res = a_sl | b_sl;
            OP_XOR:         slice_res = a_sl ^ b_sl;
            OP_NOT:         slice_res = ~a_sl;
            OP_PSA:         slice_res = a_sl;
            default:        slice_res = b_sl;
        endcase
        acc_nxt = acc;
        acc_nxt[sl_base +: SLICE] = slice_res;
    end

`ifdef SLICE_SERIAL_ALU_OVF_EN
    logic msb_cin;
    assign msb_cin = a_sl[SLICE-1] ^ b_eff[SLICE-1] ^ sum[SLICE-1];
`endif

    // Result registers change only on the final slice, so partial sums never leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            op_s      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            slice_cnt <= '0;
            ALU_OUT   <= '0;
            ALU_COUT  <= 1'b0;
            zero      <= 1'b1;
`ifdef SLICE_SERIAL_ALU_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (accept) begin
            op_a      <= a;
            op_b      <= b;
            op_s      <= s;
            carry     <= cin;
            slice_cnt <= '0;
        end else if (state == RUN) begin
            acc       <= acc_nxt;
            carry     <= slice_cout;
            slice_cnt <= last_slice ? '0 : slice_cnt + 1'b1;
            if (last_slice) begin
                ALU_OUT  <= acc_nxt;
                ALU_COUT <= slice_cout;
                zero     <= (acc_nxt == '0);
`ifdef SLICE_SERIAL_ALU_OVF_EN
                ovf      <= is_arith && (msb_cin ^ sum[SLICE]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_slice_serial_alu.sv
// Self-checking bench for slice_serial_alu: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_slice_serial_alu;

    localparam int WIDTH = 8;
    localparam int SLICE = 4;
    localparam int NSL   = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             cin = 1'b0;
    logic [2:0]       s = '0;
    logic             in_valid = 1'b0, out_ready = 1'b0;
    logic             in_ready, out_valid, ALU_COUT, zero;
    logic [WIDTH-1:0] ALU_OUT;
`ifdef SLICE_SERIAL_ALU_OVF_EN
    logic             ovf, ovf16;
`endif

    logic [15:0]      a16 = '0, b16 = '0, out16;
    logic             cin16 = 1'b0, in_valid16 = 1'b0, out_ready16 = 1'b0;
    logic [2:0]       s16 = '0;
    logic             in_ready16, out_valid16, cout16, zero16;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    slice_serial_alu #(.WIDTH(WIDTH), .SLICE(SLICE)) u_dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .s(s),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_OUT(ALU_OUT), .ALU_COUT(ALU_COUT), .zero(zero)
`ifdef SLICE_SERIAL_ALU_OVF_EN
        , .ovf(ovf)
`endif
    );

    slice_serial_alu #(.WIDTH(16), .SLICE(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16), .s(s16),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .ALU_OUT(out16), .ALU_COUT(cout16), .zero(zero16)
`ifdef SLICE_SERIAL_ALU_OVF_EN
        , .ovf(ovf16)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference result computed with whole-word arithmetic.
    function automatic void ref_op(input logic [7:0] x, input logic [7:0] y, input logic c,
                                   input logic [2:0] op, output logic [7:0] r,
                                   output logic co, output logic ov);
        logic [8:0] t;
        logic [7:0] yy;
        int sx, sy, ssum;
        co = 1'b0;
        ov = 1'b0;
        yy = (op == 3'b001) ? ~y : y;
        case (op)
            3'b000, 3'b001: begin
                t    = {1'b0, x} + {1'b0, yy} + {8'd0, c};
                r    = t[7:0];
                co   = t[8];
                sx   = x[7] ? int'(x) - 256 : int'(x);
                sy   = yy[7] ? int'(yy) - 256 : int'(yy);
                ssum = sx + sy + int'(c);
                ov   = (ssum > 127) || (ssum < -128);
            end
            3'b010:  r = x & y;
            3'b011:  r = x | y;
            3'b100:  r = x ^ y;
            3'b101:  r = ~x;
            3'b110:  r = x;
            default: r = y;
        endcase
    endfunction

    // Behavioural model: cycles remaining until the result appears, plus a "result held" flag.
    int         m_busy = 0;
    logic       m_done = 1'b0;
    logic [7:0] m_out = '0, p_out = '0;
    logic       m_cout = 1'b0, p_cout = 1'b0, m_ovf = 1'b0, p_ovf = 1'b0;
    logic       m_take;

    function automatic logic m_ready();
        return (m_busy == 0) && (!m_done || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_done = 1'b0;
            m_out  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_take = in_valid && m_ready();
            if (m_done && out_ready) m_done = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_done = 1'b1;
                    m_out  = p_out;
                    m_cout = p_cout;
                    m_ovf  = p_ovf;
                end
            end
            if (m_take) begin
                ref_op(a, b, cin, s, p_out, p_cout, p_ovf);
                m_busy = NSL;
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(m_ready()));
        check("out_valid", 32'(out_valid), 32'(m_done));
        check("alu_out", 32'(ALU_OUT), 32'(m_out));
        check("alu_cout", 32'(ALU_COUT), 32'(m_cout));
        check("zero", 32'(zero), 32'(m_out == 8'd0));
`ifdef SLICE_SERIAL_ALU_OVF_EN
        check("ovf", 32'(ovf), 32'(m_ovf));
`endif
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic c, input logic [2:0] op);
        int k;
        a = x; b = y; cin = c; s = op; in_valid = 1'b1;
        k = 0;
        while (!m_ready() && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 20) check("issue_timeout", 32'(k), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_out", 32'(ALU_OUT), 32'd0);
        check("rst_cout", 32'(ALU_COUT), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        rst_n = 1'b1;

        // Single-slice configuration: result one cycle after accept.
        a16 = 16'hFFFF; b16 = 16'h0001; s16 = 3'b000; cin16 = 1'b0; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        check("w16_run_valid", 32'(out_valid16), 32'd0);
        @(posedge clk); #1;
        check("w16_valid", 32'(out_valid16), 32'd1);
        check("w16_out", 32'(out16), 32'h0000);
        check("w16_cout", 32'(cout16), 32'd1);
        out_ready16 = 1'b1;

        issue(8'hFF, 8'h01, 1'b0, 3'b000);
        wait_valid(lat);
        check("add_latency", 32'(lat), 32'(NSL));
        check("add_out", 32'(ALU_OUT), 32'h00);
        check("add_cout", 32'(ALU_COUT), 32'd1);
        check("add_zero", 32'(zero), 32'd1);
        drain();

        issue(8'h05, 8'h07, 1'b1, 3'b001);
        wait_valid(lat);
        check("sub_out", 32'(ALU_OUT), 32'hFE);
        check("sub_cout", 32'(ALU_COUT), 32'd0);
        check("sub_zero", 32'(zero), 32'd0);
        drain();

        issue(8'hF0, 8'h3C, 1'b1, 3'b010);
        wait_valid(lat);
        check("and_out", 32'(ALU_OUT), 32'h30);
        check("and_cout", 32'(ALU_COUT), 32'd0);
        drain();

        // Backpressure: result held, then drain and accept on the same edge.
        issue(8'h10, 8'h20, 1'b0, 3'b000);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_out", 32'(ALU_OUT), 32'h30);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        a = 8'hAA; b = 8'h0F; s = 3'b100; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("drain_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_run_valid", 32'(out_valid), 32'd0);
        check("b2b_held_out", 32'(ALU_OUT), 32'h30);
        wait_valid(lat);
        check("b2b_latency", 32'(lat), 32'(NSL));
        check("b2b_out", 32'(ALU_OUT), 32'hA5);
        drain();

        // Reset one cycle into RUN aborts the operation.
        issue(8'h55, 8'h11, 1'b0, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_out", 32'(ALU_OUT), 32'h00);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("abort_valid_later", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        issue(8'h12, 8'h34, 1'b0, 3'b000);
        wait_valid(lat);
        check("post_rst_out", 32'(ALU_OUT), 32'h46);
        drain();

`ifdef SLICE_SERIAL_ALU_OVF_EN
        issue(8'h7F, 8'h01, 1'b0, 3'b000);
        wait_valid(lat);
        check("ovf_out", 32'(ALU_OUT), 32'h80);
        check("ovf_set", 32'(ovf), 32'd1);
        drain();
        issue(8'hFF, 8'h01, 1'b0, 3'b000);
        wait_valid(lat);
        check("ovf_clear", 32'(ovf), 32'd0);
        drain();
`endif

        // Randomized traffic with random backpressure and rare resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom);
            s         = 3'($urandom);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
